// File: rtl/load_unit.sv
// Wishbone read initiator for CPU byte/halfword/word loads with lane extraction and extension.
// Optional bus watchdog enabled by defining LOAD_UNIT_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module load_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [31:0] o_wb_addr,
    output logic        o_wb_cyc,
    output logic [3:0]  o_wb_stb,
    output logic        o_wb_we,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic [1:0]  i_load,
    input  logic        i_signed,
    input  logic [31:0] i_addr,
    output logic [31:0] o_data,
    output logic        o_done,
    output logic        o_error,
    output logic        o_busy
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t      state, state_next;
    logic [31:0] addr_q, addr_next;
    logic [1:0]  size_q, size_next;
    logic        signed_q, signed_next;
    logic        cyc_next, done_next, error_next;
    logic [3:0]  stb_next, req_stb;
    logic [31:0] data_next, load_value;
    logic        misaligned, tmo_expired;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

`ifdef LOAD_UNIT_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;

    // Held at zero outside BUS, so it is already clear on BUS entry.
    always_ff @(posedge i_clk) begin
        if (i_reset || state != BUS) tmo_q <= '0;
        else                         tmo_q <= tmo_q + 1'b1;
    end

    assign tmo_expired = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_expired = 1'b0;
`endif

    assign o_wb_addr = {addr_q[31:2], 2'b00};
    assign o_wb_we   = 1'b0;
    assign o_busy    = (state != IDLE);

    always_comb begin
        misaligned = ((i_load == 2'b10) && i_addr[0]) ||
                     ((i_load == 2'b11) && (i_addr[1:0] != 2'b00));
        req_stb = 4'b1111;
        case (i_load)
            2'b01:   req_stb = 4'b1000 >> i_addr[1:0];
            2'b10:   req_stb = i_addr[1] ? 4'b0011 : 4'b1100;
            default: req_stb = 4'b1111;
        endcase
    end

    // Lane 3 (bits 31:24) holds the lowest byte address.
    always_comb begin
        byte_sel = 8'h00;
        case (addr_q[1:0])
            2'b00: byte_sel = i_wb_dat[31:24];
            2'b01: byte_sel = i_wb_dat[23:16];
            2'b10: byte_sel = i_wb_dat[15:8];
            2'b11: byte_sel = i_wb_dat[7:0];
        endcase
        half_sel = addr_q[1] ? i_wb_dat[15:0] : i_wb_dat[31:16];
        case (size_q)
            2'b01:   load_value = {{24{signed_q & byte_sel[7]}}, byte_sel};
            2'b10:   load_value = {{16{signed_q & half_sel[15]}}, half_sel};
            default: load_value = i_wb_dat;
        endcase
    end

    always_comb begin
        state_next  = state;
        addr_next   = addr_q;
        size_next   = size_q;
        signed_next = signed_q;
        cyc_next    = o_wb_cyc;
        stb_next    = o_wb_stb;
        data_next   = o_data;
        done_next   = 1'b0;
        error_next  = 1'b0;
        case (state)
            IDLE: begin
                if (i_load != 2'b00) begin
                    addr_next   = i_addr;
                    size_next   = i_load;
                    signed_next = i_signed;
                    if (misaligned) begin
                        error_next = 1'b1;
                    end else begin
                        state_next = BUS;
                        cyc_next   = 1'b1;
                        stb_next   = req_stb;
                    end
                end
            end
            BUS: begin
                if (i_wb_err || i_wb_ack || tmo_expired) begin
                    state_next = RESP;
                    cyc_next   = 1'b0;
                    stb_next   = 4'b0000;
                    if (!i_wb_err && i_wb_ack) begin
                        data_next = load_value;
                        done_next = 1'b1;
                    end else begin
                        error_next = 1'b1;
                    end
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            addr_q   <= '0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 4'b0000;
            o_data   <= '0;
            o_done   <= 1'b0;
            o_error  <= 1'b0;
        end else begin
            state    <= state_next;
            addr_q   <= addr_next;
            size_q   <= size_next;
            signed_q <= signed_next;
            o_wb_cyc <= cyc_next;
            o_wb_stb <= stb_next;
            o_data   <= data_next;
            o_done   <= done_next;
            o_error  <= error_next;
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Randomised self-checking bench for load_unit against a behavioural load model.
module tb_load_unit;

`ifdef LOAD_UNIT_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        i_reset;
    logic [31:0] o_wb_addr;
    logic        o_wb_cyc;
    logic [3:0]  o_wb_stb;
    logic        o_wb_we;
    logic [31:0] i_wb_dat;
    logic        i_wb_ack;
    logic        i_wb_err;
    logic [1:0]  i_load;
    logic        i_signed;
    logic [31:0] i_addr;
    logic [31:0] o_data;
    logic        o_done;
    logic        o_error;
    logic        o_busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_data = 32'h0;

    always #5 clk = ~clk;

    load_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .o_wb_addr(o_wb_addr), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
        .i_load(i_load), .i_signed(i_signed), .i_addr(i_addr),
        .o_data(o_data), .o_done(o_done), .o_error(o_error), .o_busy(o_busy)
    );

    function automatic logic ref_mis(input logic [1:0] size, input logic [31:0] a);
        return (size == 2'd2 && (a % 2) != 0) || (size == 2'd3 && (a % 4) != 0);
    endfunction

    function automatic logic [3:0] ref_stb(input logic [1:0] size, input logic [31:0] a);
        if (size == 2'd3) return 4'b1111;
        if (size == 2'd2) return ((a % 4) == 0) ? 4'b1100 : 4'b0011;
        return 4'(8 >> (a % 4));
    endfunction

    function automatic logic [31:0] ref_data(input logic [1:0] size, input logic sgn,
                                             input logic [31:0] a, input logic [31:0] d);
        longint v;
        int unsigned sh;
        if (size == 2'd3) return d;
        if (size == 2'd1) begin
            sh = (3 - (a % 4)) * 8;
            v  = longint'((d >> sh) & 32'hFF);
            if (sgn && v >= 128) v = v - 256;
        end else begin
            sh = ((a % 4) < 2) ? 16 : 0;
            v  = longint'((d >> sh) & 32'hFFFF);
            if (sgn && v >= 32768) v = v - 65536;
        end
        return 32'(v);
    endfunction

    // kind: 0 = ack, 1 = err, 2 = ack and err together
    task automatic run_load(input logic [1:0] size, input logic sgn, input logic [31:0] a,
                            input logic [31:0] d, input int waits, input int kind, input string tag);
        logic [3:0] exp_stb;
        @(negedge clk);
        i_load = size; i_signed = sgn; i_addr = a;
        @(negedge clk);
        i_load = 2'b00; i_signed = 1'($urandom); i_addr = $urandom;
        if (ref_mis(size, a)) begin
            checks++;
            if (o_wb_cyc !== 1'b0 || o_error !== 1'b1 || o_done !== 1'b0 || o_data !== model_data) begin
                errors++;
                $display("FAIL %s misaligned_pulse: cyc=%b err=%b done=%b data=%h, want 0 1 0 %h",
                         tag, o_wb_cyc, o_error, o_done, o_data, model_data);
            end
            @(negedge clk);
            checks++;
            if (o_wb_cyc !== 1'b0 || o_error !== 1'b0 || o_busy !== 1'b0 || o_data !== model_data) begin
                errors++;
                $display("FAIL %s misaligned_after: cyc=%b err=%b busy=%b data=%h, want 0 0 0 %h",
                         tag, o_wb_cyc, o_error, o_busy, o_data, model_data);
            end
            return;
        end
        exp_stb = ref_stb(size, a);
        checks++;
        if (o_wb_cyc !== 1'b1 || o_wb_stb !== exp_stb || o_wb_addr !== (a & 32'hFFFF_FFFC) ||
            o_wb_we !== 1'b0 || o_busy !== 1'b1 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL %s bus_start: cyc=%b stb=%b addr=%h we=%b busy=%b, want 1 %b %h 0 1",
                     tag, o_wb_cyc, o_wb_stb, o_wb_addr, o_wb_we, o_busy, exp_stb, a & 32'hFFFF_FFFC);
        end
        for (int w = 0; w < waits; w++) begin
            i_load = 2'($urandom);
            @(negedge clk);
            checks++;
            if (o_wb_cyc !== 1'b1 || o_wb_stb !== exp_stb || o_done !== 1'b0 || o_error !== 1'b0) begin
                errors++;
                $display("FAIL %s bus_wait%0d: cyc=%b stb=%b done=%b err=%b, want 1 %b 0 0",
                         tag, w, o_wb_cyc, o_wb_stb, o_done, o_error, exp_stb);
            end
        end
        i_wb_dat = d; i_wb_ack = (kind != 1); i_wb_err = (kind != 0);
        @(negedge clk);
        i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_dat = $urandom; i_load = 2'b00;
        if (kind == 0) model_data = ref_data(size, sgn, a, d);
        checks++;
        if (o_wb_cyc !== 1'b0 || o_wb_stb !== 4'b0000 || o_done !== (kind == 0) ||
            o_error !== (kind != 0) || o_data !== model_data) begin
            errors++;
            $display("FAIL %s resp: cyc=%b stb=%b done=%b err=%b data=%h, want 0 0000 %b %b %h",
                     tag, o_wb_cyc, o_wb_stb, o_done, o_error, o_data, kind == 0, kind != 0, model_data);
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_error !== 1'b0 || o_busy !== 1'b0 || o_data !== model_data) begin
            errors++;
            $display("FAIL %s idle_after: done=%b err=%b busy=%b data=%h, want 0 0 0 %h",
                     tag, o_done, o_error, o_busy, o_data, model_data);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_load = 2'b00; i_signed = 1'b0; i_addr = 32'h0;
        i_wb_dat = 32'h0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_wb_cyc !== 1'b0 || o_wb_stb !== 4'b0000 || o_wb_we !== 1'b0 || o_data !== 32'h0 ||
            o_done !== 1'b0 || o_error !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: cyc=%b stb=%b we=%b data=%h done=%b err=%b busy=%b, want all zero",
                     o_wb_cyc, o_wb_stb, o_wb_we, o_data, o_done, o_error, o_busy);
        end
        i_reset = 1'b0;
        model_data = 32'h0;
    endtask

    task automatic test_directed();
        run_load(2'b01, 1'b1, 32'h0000_1001, 32'h12F4_5678, 2, 0, "signed_byte");
        run_load(2'b10, 1'b0, 32'h0000_2002, 32'hAAAA_8001, 1, 0, "unsigned_half");
        run_load(2'b11, 1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 0, 0, "word_zero_wait");
        run_load(2'b11, 1'b0, 32'h0000_4001, 32'h0, 0, 0, "misaligned_word");
        run_load(2'b10, 1'b1, 32'h0000_4003, 32'h0, 0, 0, "misaligned_half");
        run_load(2'b01, 1'b0, 32'h0000_5003, 32'h1111_1111, 1, 2, "ack_and_err");
        run_load(2'b10, 1'b1, 32'h0000_5000, 32'h2222_2222, 0, 1, "err_only");
    endtask

    task automatic test_random();
        logic [1:0]  size;
        logic [31:0] a;
        int          pick;
        for (int n = 0; n < 60; n++) begin
            size = 2'($urandom_range(1, 3));
            a    = $urandom;
            if ($urandom_range(0, 9) < 7) a = a & ~((size == 2'd3) ? 32'h3 : (size == 2'd2) ? 32'h1 : 32'h0);
            pick = $urandom_range(0, 9);
            run_load(size, 1'($urandom), a, $urandom, $urandom_range(0, 3),
                     (pick < 8) ? 0 : (pick == 8) ? 1 : 2, "random");
        end
    endtask

    task automatic test_stray_ack();
        @(negedge clk);
        i_wb_ack = 1'b1; i_wb_err = 1'b1; i_wb_dat = $urandom;
        @(negedge clk);
        i_wb_ack = 1'b0; i_wb_err = 1'b0;
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_error !== 1'b0 || o_wb_cyc !== 1'b0 || o_data !== model_data) begin
            errors++;
            $display("FAIL stray_ack: done=%b err=%b cyc=%b data=%h, want 0 0 0 %h",
                     o_done, o_error, o_wb_cyc, o_data, model_data);
        end
    endtask

    task automatic test_reset_mid_bus();
        @(negedge clk);
        i_load = 2'b01; i_signed = 1'b1; i_addr = 32'h0000_6003;
        @(negedge clk);
        i_load = 2'b00;
        checks++;
        if (o_wb_cyc !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_start: cyc=%b, want 1", o_wb_cyc);
        end
        i_reset = 1'b1;
        @(negedge clk);
        model_data = 32'h0;
        checks++;
        if (o_wb_cyc !== 1'b0 || o_wb_stb !== 4'b0000 || o_busy !== 1'b0 || o_done !== 1'b0 ||
            o_error !== 1'b0 || o_data !== model_data) begin
            errors++;
            $display("FAIL reset_mid_bus: cyc=%b stb=%b busy=%b done=%b err=%b data=%h, want all zero",
                     o_wb_cyc, o_wb_stb, o_busy, o_done, o_error, o_data);
        end
        i_reset = 1'b0; i_wb_ack = 1'b1; i_wb_dat = 32'hFFFF_FFFF;
        @(negedge clk);
        i_wb_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_error !== 1'b0 || o_wb_cyc !== 1'b0 || o_data !== model_data) begin
            errors++;
            $display("FAIL reset_mid_after: done=%b err=%b cyc=%b data=%h, want 0 0 0 %h",
                     o_done, o_error, o_wb_cyc, o_data, model_data);
        end
    endtask

    task automatic test_silent_slave();
        int n;
        @(negedge clk);
        i_load = 2'b11; i_signed = 1'b0; i_addr = 32'h0000_7000;
        @(negedge clk);
        i_load = 2'b00;
        n = 0;
`ifdef LOAD_UNIT_TIMEOUT_EN
        while (o_wb_cyc === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 8 || o_error !== 1'b1 || o_done !== 1'b0 || o_data !== model_data) begin
            errors++;
            $display("FAIL timeout: bus_cycles=%0d err=%b done=%b data=%h, want 8 1 0 %h",
                     n, o_error, o_done, o_data, model_data);
        end
        @(negedge clk);
        checks++;
        if (o_error !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_after: err=%b busy=%b, want 0 0", o_error, o_busy);
        end
`else
        while (o_wb_cyc === 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 300 || o_error !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout: bus_cycles=%0d err=%b, want 300 0", n, o_error);
        end
        i_wb_ack = 1'b1; i_wb_dat = 32'hCAFE_F00D;
        @(negedge clk);
        i_wb_ack = 1'b0;
        model_data = 32'hCAFE_F00D;
        checks++;
        if (o_done !== 1'b1 || o_data !== model_data) begin
            errors++;
            $display("FAIL no_timeout_done: done=%b data=%h, want 1 %h", o_done, o_data, model_data);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stray_ack();
        test_random();
        test_reset_mid_bus();
        test_silent_slave();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Wishbone read initiator for the CPU's load instructions; the counterpart of the store unit on the same data bus.
- Accepts a byte, halfword or word load request with an address, and runs one read cycle with byte-lane selects.
- Extracts the addressed lane(s) from the 32-bit read data, then zero- or sign-extends the result.
- Reports completion or error to the CPU pipeline with single-cycle pulses.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles to wait for ack/err before aborting; used only when LOAD_UNIT_TIMEOUT_EN is defined.

Ports:
i_clk  input  1  clock
i_reset  input  1  reset, synchronous, active-high
o_wb_addr  output  32  word-aligned bus address {addr_q[31:2],2'b00}
o_wb_cyc  output  1  bus cycle active
o_wb_stb  output  4  byte-lane strobes, lane 3 = bits 31:24 (big-endian lane order)
o_wb_we  output  1  always 0 (read-only initiator)
i_wb_dat  input  32  read data
i_wb_ack  input  1  cycle acknowledge
i_wb_err  input  1  cycle error
i_load  input  2  request: 00 none, 01 byte, 10 halfword, 11 word
i_signed  input  1  1 = sign-extend byte/halfword, 0 = zero-extend
i_addr  input  32  byte address of load
o_data  output  32  extended load result, valid when o_done
o_done  output  1  one-cycle pulse, load complete
o_error  output  1  one-cycle pulse, bus error / misaligned / timeout
o_busy  output  1  high while not IDLE

Behaviour:
- Reset values: o_wb_cyc=0, o_wb_stb=0, o_wb_we=0, o_data=0, o_done=0, o_error=0, o_busy=0; state=IDLE.
- States: IDLE, BUS, RESP.
- IDLE:
  - i_load!=0 at an edge latches size, i_signed and i_addr into addr_q, then checks alignment.
  - Misaligned = halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned: o_error pulses on the next cycle; no bus cycle; stay in IDLE.
  - Aligned: go to BUS with o_wb_cyc=1 and strobes registered on the same edge.
  - i_load is ignored while not in IDLE.
- Strobes:
  - Byte: addr[1:0] 00→1000, 01→0100, 10→0010, 11→0001.
  - Halfword: addr[1]=0→1100, addr[1]=1→0011.
  - Word: 1111.
  - Strobes hold constant for the whole cycle.
- BUS:
  - Waits for i_wb_ack or i_wb_err.
  - On either, the same edge drops o_wb_cyc and o_wb_stb to 0 and moves to RESP.
  - ack: lanes extracted from i_wb_dat and registered into o_data on that edge.
  - err: o_data is unchanged.
  - ack and err in the same cycle: err wins and the data is discarded.
- RESP: one cycle. o_done=1 (ack) or o_error=1 (err), exactly one of them. Return to IDLE.
- Latency: request edge N, o_wb_cyc high from N+1; ack sampled at edge M; o_done and o_data valid during cycle M+1. Minimum 3 cycles, request to done.
- Extension:
  - Byte: the selected lane goes to bits 7:0; bits 31:8 = lane bit 7 if i_signed, else 0.
  - Halfword: same rule with bit 15.
  - Word: passed through; i_signed is ignored.
- i_wb_ack or i_wb_err while o_wb_cyc=0 is ignored.
- o_data holds its value until the next successful load.
- Reset mid-cycle: o_wb_cyc drops on the reset edge; no o_done or o_error; state=IDLE.
- o_wb_addr is combinational from addr_q and is stable throughout the cycle.

Optional Feature:
- Macro: LOAD_UNIT_TIMEOUT_EN.
- Defined:
  - A counter clears on entering BUS and increments each BUS cycle.
  - When it reaches TIMEOUT_CYCLES without ack/err, the cycle aborts: o_wb_cyc=0, go to RESP, o_error pulses.
  - ack/err arriving on the expiry cycle takes priority over the timeout.
- Not defined: no counter; BUS waits indefinitely.

Test Plan:
- Signed byte load: i_load=01, i_signed=1, i_addr=0x1001, slave acks with 0x12F45678 after 2 wait states → o_wb_stb=0100, o_wb_we=0, o_data=0xFFFFFFF4, o_done one cycle.
- Unsigned halfword: i_load=10, i_signed=0, i_addr=0x2002, data 0xAAAA8001 → stb=0011, o_data=0x00008001.
- Word: i_addr=0x3000, data 0xDEADBEEF, zero-wait ack → stb=1111, o_wb_addr=0x3000, o_done 3 cycles after request.
- Misaligned word at 0x4001 → o_wb_cyc never asserts, o_error pulses once, o_data unchanged.
- Bus error: ack and err asserted together on a byte load → o_error pulse, no o_done, o_data keeps its previous value. Also: i_reset asserted mid-BUS → o_wb_cyc=0 next edge, no pulses.
- LOAD_UNIT_TIMEOUT_EN with TIMEOUT_CYCLES=8 and a silent slave → o_wb_cyc drops after 8 BUS cycles, o_error pulses.
